// File: rtl/avg_pool_channel_sched.sv
// avg_pool_channel_sched
//
// Shares one single-channel average-pool engine across up to NUM_CHANNELS
// channels of a frame. For each channel it selects the input with eng_ch,
// holds the engine in reset for one LOAD cycle, releases it (RUN) until
// eng_finished, then presents the captured FP32 average on a valid/ready
// port (EMIT). The engine is kept in reset whenever it is not running.
//
// Optional feature: define AVG_SCHED_TIMEOUT_EN to build a per-channel
// watchdog. If TIMEOUT_CYCLES RUN cycles pass without eng_finished, the
// channel emits FP32 NaN (32'hFFC00000) and sets the sticky timeout_err.
// Without the macro there is no counter and timeout_err is tied low.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, num_ch       frame start pulse and channel count (clamped)
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   eng_rst, eng_ch     engine reset (active high) and input mux select
//   eng_finished        engine completion level
//   eng_avg             engine result
//   out_valid/ready     result handshake
//   out_data, out_ch    captured result and its channel
//   out_last            result belongs to the final channel
//   timeout_err         sticky watchdog flag, cleared on accepted start
module avg_pool_channel_sched #(
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned NUM_CHANNELS   = 16,
    parameter int unsigned CH_W           = $clog2(NUM_CHANNELS),
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W:0]        num_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 eng_rst,
    output logic [CH_W-1:0]      eng_ch,
    input  logic                 eng_finished,
    input  logic [DATAWIDTH-1:0] eng_avg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_last,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StEmit} state_e;

    localparam logic [CH_W:0]        MaxCh  = (CH_W + 1)'(NUM_CHANNELS);
    localparam logic [DATAWIDTH-1:0] FpNan  = DATAWIDTH'(32'hFFC00000);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e        state_q;
    logic [CH_W:0] n_ch_q;          // clamped channel count of the current frame
    logic [CH_W:0] num_ch_clamped;
    logic          is_last;
    logic          wd_expired;

    assign num_ch_clamped = (num_ch > MaxCh) ? MaxCh : num_ch;
    assign is_last        = ({1'b0, eng_ch} == (n_ch_q - (CH_W + 1)'(1)));

`ifdef AVG_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wd_cnt_q;
    // Fires on the TIMEOUT_CYCLES-th RUN cycle without a finished flag.
    assign wd_expired = (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            n_ch_q    <= '0;
            eng_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            eng_ch    <= '0;
            out_ch    <= '0;
            out_data  <= '0;
`ifdef AVG_SCHED_TIMEOUT_EN
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && (num_ch != '0)) begin
                        n_ch_q  <= num_ch_clamped;
                        eng_ch  <= '0;
                        busy    <= 1'b1;
                        state_q <= StLoad;
`ifdef AVG_SCHED_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    eng_rst <= 1'b0;
                    state_q <= StRun;
`ifdef AVG_SCHED_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                StRun: begin
                    if (eng_finished || wd_expired) begin
                        // A real result always wins over a same-cycle watchdog expiry.
                        out_data  <= eng_finished ? eng_avg : FpNan;
                        out_ch    <= eng_ch;
                        out_last  <= is_last;
                        out_valid <= 1'b1;
                        eng_rst   <= 1'b1;
                        state_q   <= StEmit;
`ifdef AVG_SCHED_TIMEOUT_EN
                        if (!eng_finished) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CntW'(1);
`endif
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            // Only place eng_ch moves inside a frame.
                            eng_ch  <= eng_ch + CH_W'(1);
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_pool_channel_sched.sv
module tb_avg_pool_channel_sched;

    localparam int DW = 32;
    localparam int NC = 16;
    localparam int CW = 4;
`ifdef AVG_SCHED_TIMEOUT_EN
    localparam int TbTimeout = 64;
    localparam int EngLat    = 40;
`else
    localparam int TbTimeout = 4096;
    localparam int EngLat    = 200;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW:0]   num_ch = '0;
    logic          busy, done, eng_rst, out_valid, out_last, timeout_err;
    logic [CW-1:0] eng_ch, out_ch;
    logic          eng_finished;
    logic [DW-1:0] eng_avg, out_data;
    logic          out_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // Engine model: finishes EngLat cycles after reset release, result 1.0f + channel.
    bit eng_en = 1'b1;
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_rst) eng_cnt <= 0;
        else if (eng_cnt < EngLat) eng_cnt <= eng_cnt + 1;
    end
    assign eng_finished = eng_en && !eng_rst && (eng_cnt == EngLat);
    assign eng_avg      = 32'h3F800000 + {28'd0, eng_ch};

    always #5 clk = ~clk;

    avg_pool_channel_sched #(
        .DATAWIDTH(DW),
        .NUM_CHANNELS(NC),
        .CH_W(CW),
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_ch(num_ch),
        .busy(busy),
        .done(done),
        .eng_rst(eng_rst),
        .eng_ch(eng_ch),
        .eng_finished(eng_finished),
        .eng_avg(eng_avg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ch(out_ch),
        .out_last(out_last),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int i = 0;
        while (!out_valid && i < 2000) begin
            step();
            i++;
        end
        check("valid_seen", out_valid, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_eng_rst"}, eng_rst, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_eng_ch"}, eng_ch, 0);
        check({tag, "_out_ch"}, out_ch, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_terr"}, timeout_err, 0);
    endtask

    // Full frame with out_ready=1; optional start poke (num_ch=5) during RUN of ch 0.
    task automatic do_frame(input int req, input int nexp, input bit poke);
        num_ch = (CW + 1)'(req);
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("load_busy", busy, 1);
        check("load_eng_rst", eng_rst, 1);
        check("load_eng_ch", eng_ch, 0);
        check("start_clears_terr", timeout_err, 0);
        step();
        check("run_eng_rst", eng_rst, 0);
        if (poke) begin
            num_ch = 5'd5;
            start  = 1'b1;
            step();
            start  = 1'b0;
            num_ch = (CW + 1)'(req);
            check("poke_eng_ch", eng_ch, 0);
        end
        for (int c = 0; c < nexp; c++) begin
            wait_valid();
            check("res_data", out_data, 32'h3F800000 + c);
            check("res_ch", out_ch, c);
            check("res_last", out_last, (c == nexp - 1));
            check("emit_eng_rst", eng_rst, 1);
            check("emit_done", done, 0);
            step();
            check("post_hs_valid", out_valid, 0);
            if (c == nexp - 1) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
            end else begin
                check("next_eng_ch", eng_ch, c + 1);
                check("mid_busy", busy, 1);
            end
        end
        step();
        check("done_cleared", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_vals("rst");
        step();
        rst = 1'b1;
        step();
        check_reset_vals("after_rst");

        // Basic three-channel frame
        do_frame(3, 3, 1'b0);

        // Backpressure on a single-channel frame
        out_ready = 1'b0;
        num_ch    = 5'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_valid();
        check("bp_data", out_data, 32'h3F800000);
        check("bp_last", out_last, 1);
        for (int i = 0; i < 50; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 32'h3F800000);
            check("bp_hold_eng_rst", eng_rst, 1);
        end
        out_ready = 1'b1;
        step();
        check("bp_done", done, 1);
        check("bp_busy", busy, 0);
        step();
        check("bp_done_clr", done, 0);

        // num_ch = 0 is ignored
        num_ch = 5'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("zero_busy", busy, 0);
        step();
        check("zero_busy2", busy, 0);
        check("zero_eng_rst", eng_rst, 1);

        // num_ch = 20 clamps to 16
        do_frame(20, 16, 1'b0);

        // Start pulse during RUN has no effect
        do_frame(2, 2, 1'b1);

        // Asynchronous reset during RUN of channel 1
        num_ch = 5'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        wait_valid();
        step();
        check("mr_eng_ch", eng_ch, 1);
        step();
        check("mr_run", eng_rst, 0);
        for (int i = 0; i < 5; i++) step();
        #3 rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        step();
        step();
        rst = 1'b1;
        step();
        do_frame(2, 2, 1'b0);

        // Engine never finishes
        eng_en = 1'b0;
        num_ch = 5'd2;
        start  = 1'b1;
        step();
        start = 1'b0;
`ifdef AVG_SCHED_TIMEOUT_EN
        for (int c = 0; c < 2; c++) begin
            wait_valid();
            check("to_data", out_data, 32'hFFC00000);
            check("to_ch", out_ch, c);
            check("to_terr", timeout_err, 1);
            step();
        end
        check("to_done", done, 1);
        step();
        check("to_terr_sticky", timeout_err, 1);
        eng_en = 1'b1;
        do_frame(1, 1, 1'b0);
`else
        for (int i = 0; i < 300; i++) step();
        check("hang_valid", out_valid, 0);
        check("hang_busy", busy, 1);
        check("hang_terr", timeout_err, 0);
        rst = 1'b0;
        step();
        rst    = 1'b1;
        eng_en = 1'b1;
        step();
        check("hang_recover_busy", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avg_pool_channel_sched.md
# avg_pool_channel_sched

Sequencer for one shared single-channel average-pool engine across up to NUM_CHANNELS feature-map channels. It holds the engine in reset and selects a channel through the input-matrix mux (eng_ch). It releases the engine and waits for its finished flag, then streams each FP32 average out with a valid/ready handshake. It sits between the layer controller (start/num_ch) and the pooled-output buffer.

## Interface
- DATAWIDTH, 32, FP32 word width of engine result and out_data
- NUM_CHANNELS, 16, maximum channels per frame
- CH_W, $clog2(NUM_CHANNELS), width of channel index
- TIMEOUT_CYCLES, 4096, watchdog limit per channel (used only with AVG_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- num_ch  in  CH_W+1  channels in frame; 0 ignored, >NUM_CHANNELS clamped
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after last channel handshake
- eng_rst  out  1  active-high reset to engine
- eng_ch  out  CH_W  channel select for engine input mux
- eng_finished  in  1  engine completion flag (level)
- eng_avg  in  DATAWIDTH  engine average result
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  DATAWIDTH  captured average
- out_ch  out  CH_W  channel of out_data
- out_last  out  1  high with the final channel's result
- timeout_err  out  1  sticky watchdog flag; cleared on accepted start

## Operation
- FSM states: IDLE, LOAD, RUN, EMIT.
- IDLE: eng_rst=1, busy=0. start=1 with num_ch≠0 → latch n=min(num_ch,NUM_CHANNELS), eng_ch=0, clear timeout_err → LOAD.
- LOAD: eng_rst=1 for exactly one cycle; watchdog cleared → RUN.
- RUN: eng_rst=0. eng_finished=1 → capture eng_avg into out_data, eng_ch into out_ch, out_last=(eng_ch==n-1) → EMIT.
- EMIT: eng_rst=1, out_valid=1, out_data/out_ch/out_last stable. out_valid&out_ready → if out_last: done pulse, → IDLE; else eng_ch+1 → LOAD.
- eng_ch changes only on EMIT exit, so the mux is stable during the whole of LOAD and RUN.
- start while busy is ignored. start with num_ch=0 is ignored and busy stays 0.
- Data is passed through unmodified; the block performs no arithmetic on FP32 values.

## Timing
- Reset values: eng_rst=1, busy=0, done=0, out_valid=0, out_last=0, eng_ch=0, out_ch=0, out_data=0, timeout_err=0; state=IDLE.
- Reset asserted mid-frame → immediate return to reset values. The engine is held in reset and the frame is discarded.
- start at edge k → LOAD during k+1 (busy=1), RUN from k+2.
- eng_finished seen in RUN at edge m → out_valid=1 from m+1.
- Throughput with out_ready=1: one result per (engine latency + 3) cycles.
- Handshake: out_valid never drops without out_ready. Backpressure stalls in EMIT indefinitely, and the engine stays in reset meanwhile.
- done asserts the cycle after the final handshake; busy falls in the same cycle.
- eng_finished is ignored outside RUN.

## Configuration
- AVG_SCHED_TIMEOUT_EN defined: RUN counts cycles. If TIMEOUT_CYCLES elapse without eng_finished, then:
  - out_data=32'hFFC00000 (FP32 NaN),
  - timeout_err is set,
  - the FSM moves to EMIT normally and the frame continues.
- Not defined: no counter is built, RUN waits indefinitely, and timeout_err is tied 0.

## Test plan
- Bench engine model: raises finished 200 cycles after its reset deasserts and returns eng_avg=32'h3F800000+eng_ch. Stimulus: start, num_ch=3, out_ready=1 → three results with out_data 3F800000/3F800001/3F800002, out_ch 0/1/2, out_last only on ch 2, then a one-cycle done.
- num_ch=1, out_ready held 0 for 50 cycles after out_valid → out_valid and out_data stable for all 50 cycles, eng_rst=1; one handshake then done.
- start with num_ch=0, then num_ch=20 → first ignored (busy stays 0). Second is clamped to 16 results, out_last on ch 15.
- rst driven low during RUN of ch 1 → all outputs take reset values asynchronously. A new start restarts at eng_ch=0.
- start pulsed in RUN → no effect on channel count or sequence.
- AVG_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=64 and the engine never finishing → out_data=FFC00000 per channel, timeout_err=1 until next start. Without the macro, busy stays 1 and there is no output.
